// File: rtl/data_pack_collector.sv
// Packs PACK_NUM DSIZE-bit bytes into one word, flushing early on in_last; optional frame_cnt under DATA_PACK_COLLECTOR_FRAME_CNT_EN.
// Latency: out_valid rises the cycle after the completing input transfer.
// Backpressure: in_ready drops while a word waits in DONE; out_ready only releases the held word.
module data_pack_collector #(
  parameter int DSIZE    = 8,
  parameter int PACK_NUM = 4
) (
  input  logic                      clock,
  input  logic                      rst,
  input  logic [DSIZE-1:0]          in_data,
  input  logic                      in_valid,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic [DSIZE*PACK_NUM-1:0] out_data,
  output logic [PACK_NUM-1:0]       out_keep,
  output logic                      out_last,
  output logic                      out_valid,
`ifdef DATA_PACK_COLLECTOR_FRAME_CNT_EN
  output logic [15:0]               frame_cnt,
`endif
  input  logic                      out_ready
);

  localparam int IW = $clog2(PACK_NUM) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(PACK_NUM - 1);
  localparam bit SINGLE = (PACK_NUM == 1);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t                    state, state_nxt;
  logic [IW-1:0]             idx, idx_nxt;
  logic [DSIZE*PACK_NUM-1:0] data_nxt;
  logic [PACK_NUM-1:0]       keep_nxt;
  logic                      last_nxt;

  assign in_ready  = (state == IDLE || state == EXEC) && !rst;
  assign out_valid = (state == DONE);

  always_ff @(posedge clock) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      out_data <= '0;
      out_keep <= '0;
      out_last <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      out_data <= data_nxt;
      out_keep <= keep_nxt;
      out_last <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    data_nxt  = out_data;
    keep_nxt  = out_keep;
    last_nxt  = out_last;
    case (state)
      IDLE: begin
        if (in_valid) begin
          data_nxt              = '0;
          data_nxt[DSIZE-1:0]   = in_data;
          keep_nxt              = '0;
          keep_nxt[0]           = 1'b1;
          last_nxt              = in_last;
          idx_nxt               = IW'(1);
          state_nxt             = (in_last || SINGLE) ? DONE : EXEC;
        end
      end
      EXEC: begin
        if (in_valid) begin
          for (int k = 0; k < PACK_NUM; k++) begin
            if (idx == IW'(k)) begin
              data_nxt[k*DSIZE +: DSIZE] = in_data;
              keep_nxt[k]                = 1'b1;
            end
          end
          last_nxt  = in_last;
          idx_nxt   = idx + IW'(1);
          state_nxt = (in_last || idx == LAST_IDX) ? DONE : EXEC;
        end
      end
      DONE: begin
        if (out_ready) begin
          data_nxt  = '0;
          keep_nxt  = '0;
          last_nxt  = 1'b0;
          idx_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: begin
        data_nxt  = '0;
        keep_nxt  = '0;
        last_nxt  = 1'b0;
        idx_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef DATA_PACK_COLLECTOR_FRAME_CNT_EN
  // Counts completed frames, not words; wraps naturally at 16 bits.
  always_ff @(posedge clock) begin
    if (rst)
      frame_cnt <= '0;
    else if (out_valid && out_ready && out_last)
      frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_data_pack_collector.sv
// Directed bench for data_pack_collector (PACK_NUM=4) with an expected-word scoreboard.
module tb_data_pack_collector;

  localparam int DSIZE = 8;
  localparam int PN    = 4;

  typedef struct packed {
    logic [DSIZE*PN-1:0] data;
    logic [PN-1:0]       keep;
    logic                last;
  } exp_t;

  logic                clock = 1'b0;
  logic                rst;
  logic [DSIZE-1:0]    in_data;
  logic                in_valid;
  logic                in_last;
  logic                in_ready;
  logic [DSIZE*PN-1:0] out_data;
  logic [PN-1:0]       out_keep;
  logic                out_last;
  logic                out_valid;
  logic                out_ready;
`ifdef DATA_PACK_COLLECTOR_FRAME_CNT_EN
  logic [15:0]         frame_cnt;
`endif

  int   errors = 0;
  int   checks = 0;
  int   pushed = 0;
  int   popped = 0;
  exp_t exp_q[$];

  data_pack_collector #(.DSIZE(DSIZE), .PACK_NUM(PN)) dut (
    .clock    (clock),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_keep (out_keep),
    .out_last (out_last),
    .out_valid(out_valid),
`ifdef DATA_PACK_COLLECTOR_FRAME_CNT_EN
    .frame_cnt(frame_cnt),
`endif
    .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Output side of the scoreboard: every handshake must match the oldest expected word.
  always @(negedge clock) begin
    if (!rst && out_valid && out_ready) begin
      check("out_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        popped++;
        check("out_data", 64'(out_data), 64'(e.data));
        check("out_keep", 64'(out_keep), 64'(e.keep));
        check("out_last", 64'(out_last), 64'(e.last));
      end
    end
  end

  task automatic push_exp(input logic [31:0] d, input logic [3:0] k, input logic l);
    exp_t e;
    e.data = d;
    e.keep = k;
    e.last = l;
    exp_q.push_back(e);
    pushed++;
  endtask

  // Called just after a posedge; returns just after the posedge that accepted the byte.
  task automatic put_byte(input logic [7:0] d, input logic l);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clock);
      if (in_ready) ok = 1'b1;
      else @(posedge clock) #1;
    end
    check("in_ready_timeout", 64'(ok), 64'd1);
    @(posedge clock) #1;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(negedge clock);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clock) #1;
  endtask

  initial begin
    logic [31:0] w;
    logic [3:0]  k;
    logic        l;
    int          len;
    logic [7:0]  b;

    rst = 1'b1; out_ready = 1'b1;
    idle_in();
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_keep", 64'(out_keep), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
`ifdef DATA_PACK_COLLECTOR_FRAME_CNT_EN
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
`endif
    @(posedge clock) #1;
    rst = 1'b0;
    @(negedge clock);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clock) #1;

    // Full word, out_valid for exactly one cycle.
    push_exp(32'h44332211, 4'hF, 1'b0);
    put_byte(8'h11, 0); put_byte(8'h22, 0); put_byte(8'h33, 0); put_byte(8'h44, 0);
    idle_in();
    @(negedge clock);
    check("t1_out_valid", 64'(out_valid), 64'd1);
    check("t1_in_ready", 64'(in_ready), 64'd0);
    @(negedge clock);
    check("t1_out_valid_drop", 64'(out_valid), 64'd0);
    check("t1_in_ready_back", 64'(in_ready), 64'd1);
    @(posedge clock) #1;

    // Short frame flushed by in_last.
    push_exp(32'h00001209, 4'b0011, 1'b1);
    put_byte(8'h09, 0); put_byte(8'h12, 1);
    idle_in();
    drain();
`ifdef DATA_PACK_COLLECTOR_FRAME_CNT_EN
    check("t2_frame_cnt", 64'(frame_cnt), 64'd1);
`endif

    // Held word under backpressure, with in_valid junk that must be ignored.
    out_ready = 1'b0;
    push_exp(32'h04030201, 4'hF, 1'b0);
    put_byte(8'h01, 0); put_byte(8'h02, 0); put_byte(8'h03, 0); put_byte(8'h04, 0);
    in_valid = 1'b1; in_data = 8'hEE; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("t3_hold_valid", 64'(out_valid), 64'd1);
      check("t3_hold_in_ready", 64'(in_ready), 64'd0);
      check("t3_hold_data", 64'(out_data), 64'h04030201);
    end
    @(posedge clock) #1;
    idle_in();
    out_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("t3_released", 64'(out_valid), 64'd0);
    check("t3_q_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clock) #1;

    // Single-byte frame from IDLE.
    push_exp(32'h000000FF, 4'b0001, 1'b1);
    put_byte(8'hFF, 1);
    idle_in();
    @(negedge clock);
    check("t4_out_valid", 64'(out_valid), 64'd1);
    drain();
`ifdef DATA_PACK_COLLECTOR_FRAME_CNT_EN
    check("t4_frame_cnt", 64'(frame_cnt), 64'd2);
`endif

    // in_last without in_valid must not flush.
    push_exp(32'hDDCCBBAA, 4'hF, 1'b0);
    put_byte(8'hAA, 0);
    in_valid = 1'b0; in_last = 1'b1; in_data = 8'h77;
    repeat (2) begin
      @(negedge clock);
      check("gap_no_valid", 64'(out_valid), 64'd0);
      check("gap_in_ready", 64'(in_ready), 64'd1);
      @(posedge clock) #1;
    end
    put_byte(8'hBB, 0); put_byte(8'hCC, 0); put_byte(8'hDD, 0);
    idle_in();
    drain();

    // Reset mid-word discards the partial word.
    put_byte(8'h55, 0); put_byte(8'h66, 0);
    idle_in();
    rst = 1'b1;
    @(negedge clock);
    check("t5_rst_valid", 64'(out_valid), 64'd0);
    check("t5_rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clock) #1;
    rst = 1'b0;
    @(negedge clock);
    check("t5_keep_cleared", 64'(out_keep), 64'd0);
    check("t5_out_valid", 64'(out_valid), 64'd0);
    @(posedge clock) #1;
    push_exp(32'hA3A2A1A0, 4'hF, 1'b0);
    put_byte(8'hA0, 0); put_byte(8'hA1, 0); put_byte(8'hA2, 0); put_byte(8'hA3, 0);
    idle_in();
    drain();

    // Random-length frames.
    for (int f = 0; f < 10; f++) begin
      len = $urandom_range(1, 4);
      l   = (len < 4) ? 1'b1 : 1'($urandom_range(0, 1));
      w = '0; k = '0;
      for (int i = 0; i < len; i++) begin
        b = 8'($urandom);
        w[i*8 +: 8] = b;
        k[i] = 1'b1;
      end
      push_exp(w, k, l);
      for (int i = 0; i < len; i++) put_byte(w[i*8 +: 8], (i == len - 1) ? l : 1'b0);
      idle_in();
      drain();
    end

    check("word_count", 64'(popped), 64'(pushed));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
